// File: rtl/icache_if.sv
// Datapath-side and memory-side signals of the direct-mapped instruction cache.
// slave = cache side, master = datapath/memory side (driver of requests and fill data).
interface icache_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave  (input  imemREN, imemaddr, iwait, iload,
                    output ihit, imemload, iREN, iaddr);
    modport master (output imemREN, imemaddr, iwait, iload,
                    input  ihit, imemload, iREN, iaddr);
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-entry instruction cache with a two-state fill FSM.
// Optional ICACHE_STATS_EN adds hit_count / miss_count outputs.
module icache #(
    parameter int          SETS    = 16,
    parameter logic [31:0] PC_INIT = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    icache_if.slave     bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t             state, state_n;
    logic [SETS-1:0]    valid;
    logic [TAG_W-1:0]   tags [SETS];
    logic [31:0]        data [SETS];
    logic [31:0]        last_addr;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               fill;
    logic               unused_ok;

    assign idx       = bus.imemaddr[IDX_W+1:2];
    assign tag       = bus.imemaddr[31:IDX_W+2];
    assign hit       = valid[idx] && (tags[idx] == tag);
    assign unused_ok = ^bus.imemaddr[1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n      = state;
        bus.ihit     = 1'b0;
        bus.imemload = 32'h0;
        bus.iREN     = 1'b0;
        bus.iaddr    = last_addr;
        fill         = 1'b0;
        case (state)
            IDLE: begin
                if (bus.imemREN) begin
                    if (hit) begin
                        bus.ihit     = 1'b1;
                        bus.imemload = data[idx];
                    end else begin
                        state_n = FETCH;
                    end
                end
            end
            FETCH: begin
                // live address: the datapath holds pc stable while ihit is low
                bus.iREN  = 1'b1;
                bus.iaddr = {bus.imemaddr[31:2], 2'b00};
                if (!bus.iwait) begin
                    fill    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid     <= '0;
            last_addr <= PC_INIT;
        end else begin
            if (state == FETCH) last_addr <= bus.iaddr;
            if (fill)           valid[idx] <= 1'b1;
        end
    end

    // tag/data need no reset: valid gates every use
    always_ff @(posedge CLK) begin
        if (fill) begin
            tags[idx] <= tag;
            data[idx] <= bus.iload;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (bus.ihit)                                   hit_count  <= hit_count + 32'd1;
            if (state == IDLE && bus.imemREN && !hit)       miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hit, conflict, wait stretch, reset mid-fill, stats.
module tb_icache;
    logic CLK = 1'b0;
    logic RST;
    int   total = 0;
    int   bad   = 0;

    localparam logic [31:0] D1 = 32'h8C220004;
    localparam logic [31:0] D2 = 32'h11112222;
    localparam logic [31:0] D3 = 32'hA5A50003;
    localparam logic [31:0] D4 = 32'h0BADF00D;
    localparam logic [31:0] D5 = 32'h12345678;

    icache_if bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
    icache dut (.CLK(CLK), .RST(RST), .bus(bus), .hit_count(hit_count), .miss_count(miss_count));
`else
    icache dut (.CLK(CLK), .RST(RST), .bus(bus));
`endif

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    // miss at addr, nwait busy FETCH cycles, then fill; ends one cycle after the hit cycle
    task automatic do_miss(input logic [31:0] addr, input logic [31:0] d, input int nwait);
        bus.imemREN = 1'b1; bus.imemaddr = addr; bus.iwait = 1'b1; bus.iload = 32'hFFFFFFFF;
        smp();
        chk("miss_ihit", {31'b0, bus.ihit}, 32'd0);
        chk("miss_load", bus.imemload, 32'h0);
        nxt();
        for (int i = 0; i < nwait; i++) begin
            smp();
            chk("wait_iREN", {31'b0, bus.iREN}, 32'd1);
            chk("wait_iaddr", bus.iaddr, addr);
            chk("wait_ihit", {31'b0, bus.ihit}, 32'd0);
            nxt();
        end
        bus.iwait = 1'b0; bus.iload = d;
        smp();
        chk("fetch_iREN", {31'b0, bus.iREN}, 32'd1);
        chk("fetch_iaddr", bus.iaddr, addr);
        chk("fetch_ihit", {31'b0, bus.ihit}, 32'd0);
        nxt();
        bus.iwait = 1'b1; bus.iload = 32'hFFFFFFFF;
        smp();
        chk("fill_ihit", {31'b0, bus.ihit}, 32'd1);
        chk("fill_load", bus.imemload, d);
        chk("fill_iREN", {31'b0, bus.iREN}, 32'd0);
        chk("fill_iaddr_hold", bus.iaddr, addr);
        nxt();
        bus.imemREN = 1'b0;
    endtask

    task automatic do_hit(input logic [31:0] addr, input logic [31:0] d);
        bus.imemREN = 1'b1; bus.imemaddr = addr;
        smp();
        chk("hit_ihit", {31'b0, bus.ihit}, 32'd1);
        chk("hit_load", bus.imemload, d);
        chk("hit_iREN", {31'b0, bus.iREN}, 32'd0);
        nxt();
        bus.imemREN = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        bus.imemREN = 1'b0; bus.imemaddr = 32'h0; bus.iwait = 1'b1; bus.iload = 32'h0;
        repeat (2) @(posedge CLK);
        #1 bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
        smp();
        chk("rst_ihit", {31'b0, bus.ihit}, 32'd0);
        chk("rst_load", bus.imemload, 32'h0);
        chk("rst_iREN", {31'b0, bus.iREN}, 32'd0);
        chk("rst_iaddr", bus.iaddr, 32'h0);
`ifdef ICACHE_STATS_EN
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_miss", miss_count, 32'd0);
`endif
        nxt();
        RST = 1'b0; bus.imemREN = 1'b0;

        // no request keeps IDLE
        smp();
        chk("idle_ihit", {31'b0, bus.ihit}, 32'd0);
        nxt();
        smp();
        chk("idle_iREN", {31'b0, bus.iREN}, 32'd0);
        nxt();

        // cold miss then hit
        do_miss(32'h40, D1, 0);
        do_hit(32'h40, D1);
`ifdef ICACHE_STATS_EN
        chk("miss_after_hit", miss_count, 32'd1);
`endif
        // cached address but no request: outputs stay zero
        bus.imemaddr = 32'h40;
        smp();
        chk("noreq_ihit", {31'b0, bus.ihit}, 32'd0);
        chk("noreq_load", bus.imemload, 32'h0);
        nxt();

        // conflict on index 0
        do_miss(32'h440, D2, 0);
        do_hit(32'h440, D2);
        do_miss(32'h40, D1, 0);

        // wait stretch on a different index; index 0 untouched
        do_miss(32'h44, D3, 5);
        do_hit(32'h40, D1);
        do_hit(32'h44, D3);

        // reset asserted mid-FETCH
        bus.imemREN = 1'b1; bus.imemaddr = 32'h80; bus.iwait = 1'b1;
        nxt();
        smp();
        chk("mid_iREN_pre", {31'b0, bus.iREN}, 32'd1);
        RST = 1'b1;
        #1;
        chk("mid_iREN_rst", {31'b0, bus.iREN}, 32'd0);
        chk("mid_iaddr_rst", bus.iaddr, 32'h0);
        chk("mid_ihit_rst", {31'b0, bus.ihit}, 32'd0);
        bus.iwait = 1'b0; bus.iload = 32'hDEADBEEF;
        nxt();
        RST = 1'b0;
        do_miss(32'h80, D4, 1);
        do_miss(32'h44, D3, 0);

        // stats: 3 misses and 10 hit cycles after a fresh reset
        RST = 1'b1;
        nxt();
        RST = 1'b0;
        do_miss(32'h100, D5, 0);
        do_miss(32'h104, D1, 2);
        do_miss(32'h108, D2, 0);
        for (int i = 0; i < 7; i++) do_hit(32'h100, D5);
        smp();
`ifdef ICACHE_STATS_EN
        chk("stat_miss", miss_count, 32'd3);
        chk("stat_hits", hit_count, 32'd10);
`endif
        chk("end_iREN", {31'b0, bus.iREN}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
